pipe_stage_elastic: RTL and testbench



---
 rtl/cpu_pkg.sv | 39 +++
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_stage_elastic.sv | 133 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants, occupancy encodings and stage field layouts
// Stage structs fix the payload width each pipe_stage_elastic instance carries.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] PC_RST_DEFAULT = 32'h0000_3000;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;
  } de_fields_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] rt_val;
    logic [4:0]  dst_reg;
    logic [26:0] rsvd;
  } em_fields_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] mem_rdata;
    logic [4:0]  dst_reg;
    logic [26:0] rsvd;
  } mw_fields_t;

  localparam int DE_W = $bits(de_fields_t);
  localparam int EM_W = $bits(em_fields_t);
  localparam int MW_W = $bits(mw_fields_t);

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Sticks at all-ones so long stalls never wrap back to a small count.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic inter-stage register with optional skid entry
// The main entry is always the head; an empty stage presents a nop payload and PC_RST.
module pipe_stage_elastic
  import cpu_pkg::*;
#(
  parameter int          DATA_W = DE_W,
  parameter logic [31:0] PC_RST = PC_RST_DEFAULT,
  parameter bit          SKID   = 1'b1,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [31:0]       main_pc_q, main_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [31:0]       skid_pc_q, skid_pc_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;
  logic              pop;
  logic              stall_inc;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = main_data_q;
  assign out_pc    = main_pc_q;
  assign occupancy = occ_q;

  // Skid mode breaks the out_ready -> in_ready path; otherwise pass it straight through.
  assign in_ready = SKID ? in_ready_q : ((occ_q == OCC_EMPTY) | out_ready);

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    occ_d       = occ_q;
    main_data_d = main_data_q;
    main_pc_d   = main_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    if (flush) begin
      occ_d       = OCC_EMPTY;
      main_data_d = '0;
      main_pc_d   = PC_RST;
      skid_data_d = '0;
      skid_pc_d   = PC_RST;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d       = OCC_ONE;
            main_data_d = in_data;
            main_pc_d   = in_pc;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            main_data_d = in_data;
            main_pc_d   = in_pc;
          end else if (accept && SKID) begin
            occ_d       = OCC_FULL;
            skid_data_d = in_data;
            skid_pc_d   = in_pc;
          end else if (pop && !accept) begin
            occ_d       = OCC_EMPTY;
            main_data_d = '0;
            main_pc_d   = PC_RST;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            occ_d       = OCC_ONE;
            main_data_d = skid_data_q;
            main_pc_d   = skid_pc_q;
            skid_data_d = '0;
            skid_pc_d   = PC_RST;
          end
        end
        default: begin
          occ_d       = OCC_EMPTY;
          main_data_d = '0;
          main_pc_d   = PC_RST;
          skid_data_d = '0;
          skid_pc_d   = PC_RST;
        end
      endcase
    end
    in_ready_d = (occ_d != OCC_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= OCC_EMPTY;
      main_data_q <= '0;
      main_pc_q   <= PC_RST;
      skid_data_q <= '0;
      skid_pc_q   <= PC_RST;
      in_ready_q  <= 1'b1;
    end else begin
      occ_q       <= occ_d;
      main_data_q <= main_data_d;
      main_pc_q   <= main_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // A flushed cycle is a bubble, not a stall, so it does not count.
  assign stall_inc = out_valid & ~out_ready & ~flush;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (stall_inc),
    .value(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic (skid and no-skid builds)
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst = 1'b1, a_fl = 1'b0, a_iv = 1'b0, a_ordy = 1'b0;
  logic         a_ir, a_ov;
  logic [127:0] a_id = '0, a_od;
  logic [31:0]  a_ipc = '0, a_opc;
  logic [1:0]   a_occ;
  logic [3:0]   a_sc;

  logic         b_rst = 1'b1, b_fl = 1'b0, b_iv = 1'b0, b_ordy = 1'b0;
  logic         b_ir, b_ov;
  logic [127:0] b_id = '0, b_od;
  logic [31:0]  b_ipc = '0, b_opc;
  logic [1:0]   b_occ;
  logic [15:0]  b_sc;

  pipe_stage_elastic #(.SKID(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(a_rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_pc(a_ipc), .out_valid(a_ov), .out_ready(a_ordy),
    .out_data(a_od), .out_pc(a_opc), .occupancy(a_occ), .stall_cnt(a_sc)
  );

  pipe_stage_elastic #(.SKID(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(b_rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_pc(b_ipc), .out_valid(b_ov), .out_ready(b_ordy),
    .out_data(b_od), .out_pc(b_opc), .occupancy(b_occ), .stall_cnt(b_sc)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a FIFO of {pc, data} per instance plus a plain stall tally.
  int           m_n[2];
  int           m_sc[2];
  logic [31:0]  m_pc[2][2];
  logic [127:0] m_d[2][2];

  logic         s_ov, s_ir;
  logic [31:0]  s_pc;
  logic [127:0] s_d;
  logic [1:0]   s_occ;
  logic [15:0]  s_sc;

  typedef struct {
    bit          r, f, iv;
    logic [31:0] pc;
    bit          ordy, chk, ov;
    logic [31:0] opc;
    logic [1:0]  occ;
    bit          ir;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(int r, int f, int iv, logic [31:0] pc, int ordy, int chk,
                              int ov, logic [31:0] opc, int occ, int ir, int sc);
    vec_t v;
    v.r = r[0]; v.f = f[0]; v.iv = iv[0]; v.pc = pc; v.ordy = ordy[0]; v.chk = chk[0];
    v.ov = ov[0]; v.opc = opc; v.occ = occ[1:0]; v.ir = ir[0]; v.sc = sc[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle(input int k, input bit r, input bit f, input bit iv, input logic [31:0] pc,
                       input logic [127:0] d, input bit ordy, input bit mchk, input string tag);
    bit rdy, acc, pop;
    int cap, smax;
    @(negedge clk);
    if (k == 0) begin
      a_rst = r; a_fl = f; a_iv = iv; a_ipc = pc; a_id = d; a_ordy = ordy;
    end else begin
      b_rst = r; b_fl = f; b_iv = iv; b_ipc = pc; b_id = d; b_ordy = ordy;
    end
    #1;
    if (k == 0) begin
      s_ov = a_ov; s_ir = a_ir; s_pc = a_opc; s_d = a_od; s_occ = a_occ; s_sc = {12'h0, a_sc};
    end else begin
      s_ov = b_ov; s_ir = b_ir; s_pc = b_opc; s_d = b_od; s_occ = b_occ; s_sc = b_sc;
    end
    cap  = (k == 0) ? 2 : 1;
    smax = (k == 0) ? 15 : 65535;
    rdy  = (k == 0) ? (m_n[k] < 2) : ((m_n[k] == 0) || ordy);
    if (mchk) begin
      chk({tag, " out_valid"}, s_ov, (m_n[k] > 0));
      chk({tag, " out_pc"}, s_pc, (m_n[k] > 0) ? m_pc[k][0] : 32'h3000);
      chk({tag, " out_data"}, s_d, (m_n[k] > 0) ? m_d[k][0] : 128'h0);
      chk({tag, " occupancy"}, s_occ, m_n[k]);
      chk({tag, " in_ready"}, s_ir, rdy);
      chk({tag, " stall_cnt"}, s_sc, m_sc[k]);
    end
    @(posedge clk);
    acc = iv && rdy;
    pop = (m_n[k] > 0) && ordy;
    if (r) begin
      m_n[k] = 0;
      m_sc[k] = 0;
    end else begin
      if ((m_n[k] > 0) && !ordy && !f && (m_sc[k] < smax)) m_sc[k]++;
      if (f) begin
        m_n[k] = 0;
      end else begin
        if (pop) begin
          m_pc[k][0] = m_pc[k][1];
          m_d[k][0]  = m_d[k][1];
          m_n[k]--;
        end
        if (acc && (m_n[k] < cap)) begin
          m_pc[k][m_n[k]] = pc;
          m_d[k][m_n[k]]  = d;
          m_n[k]++;
        end
      end
    end
  endtask

  initial begin
    string tag;
    // r f iv pc ordy chk | ov out_pc occ in_ready stall_cnt
    tbl[0]  = mk(1, 0, 0, 32'h0,    1, 0, 0, 32'h3000, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 32'h0,    1, 1, 0, 32'h3000, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,    1, 1, 0, 32'h3000, 0, 1, 0);
    tbl[3]  = mk(0, 0, 1, 32'h3000, 1, 1, 0, 32'h3000, 0, 1, 0);
    tbl[4]  = mk(0, 0, 1, 32'h3004, 1, 1, 1, 32'h3000, 1, 1, 0);
    tbl[5]  = mk(0, 0, 1, 32'h3008, 1, 1, 1, 32'h3004, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 32'h0,    1, 1, 1, 32'h3008, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 32'h0,    1, 1, 0, 32'h3000, 0, 1, 0);
    tbl[8]  = mk(0, 0, 1, 32'h3000, 0, 1, 0, 32'h3000, 0, 1, 0);
    tbl[9]  = mk(0, 0, 1, 32'h3004, 0, 1, 1, 32'h3000, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 32'h0,    0, 1, 1, 32'h3000, 2, 0, 1);
    tbl[11] = mk(0, 0, 0, 32'h0,    0, 1, 1, 32'h3000, 2, 0, 2);
    tbl[12] = mk(0, 0, 0, 32'h0,    0, 1, 1, 32'h3000, 2, 0, 3);
    tbl[13] = mk(0, 0, 0, 32'h0,    0, 1, 1, 32'h3000, 2, 0, 4);
    tbl[14] = mk(0, 0, 0, 32'h0,    1, 1, 1, 32'h3000, 2, 0, 5);
    tbl[15] = mk(0, 0, 0, 32'h0,    1, 1, 1, 32'h3004, 1, 1, 5);
    tbl[16] = mk(0, 0, 0, 32'h0,    1, 1, 0, 32'h3000, 0, 1, 5);
    tbl[17] = mk(0, 0, 1, 32'h3020, 0, 1, 0, 32'h3000, 0, 1, 5);
    tbl[18] = mk(0, 0, 1, 32'h3024, 0, 1, 1, 32'h3020, 1, 1, 5);
    tbl[19] = mk(0, 1, 1, 32'h3010, 0, 1, 1, 32'h3020, 2, 0, 6);
    tbl[20] = mk(0, 0, 0, 32'h0,    1, 1, 0, 32'h3000, 0, 1, 6);
    tbl[21] = mk(0, 0, 1, 32'h3030, 1, 1, 0, 32'h3000, 0, 1, 6);
    tbl[22] = mk(0, 1, 1, 32'h3010, 1, 1, 1, 32'h3030, 1, 1, 6);
    tbl[23] = mk(0, 0, 0, 32'h0,    1, 1, 0, 32'h3000, 0, 1, 6);

    for (int i = 0; i < 24; i++) begin
      cycle(0, tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, {4{tbl[i].pc}}, tbl[i].ordy,
            tbl[i].chk, $sformatf("model row%0d", i));
      if (tbl[i].chk) begin
        tag = $sformatf("tbl row%0d", i);
        chk({tag, " out_valid"}, s_ov, tbl[i].ov);
        chk({tag, " out_pc"}, s_pc, tbl[i].opc);
        chk({tag, " out_data"}, s_d, tbl[i].ov ? {4{tbl[i].opc}} : 128'h0);
        chk({tag, " occupancy"}, s_occ, tbl[i].occ);
        chk({tag, " in_ready"}, s_ir, tbl[i].ir);
        chk({tag, " stall_cnt"}, s_sc, tbl[i].sc);
      end
    end

    // Saturation of the 4-bit counter, then reset in the middle of the stall.
    cycle(0, 0, 0, 1, 32'h3040, {4{32'h3040}}, 0, 1, "sat push");
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 32'h0, '0, 0, 1, $sformatf("sat%0d", i));
    cycle(0, 0, 0, 0, 32'h0, '0, 0, 1, "sat hold");
    chk("sat stall_cnt", s_sc, 16'd15);
    chk("sat out_pc", s_pc, 32'h3040);
    cycle(0, 1, 0, 1, 32'h3050, {4{32'h3050}}, 0, 1, "mid reset");
    cycle(0, 0, 0, 0, 32'h0, '0, 0, 1, "post reset");
    chk("post reset out_valid", s_ov, 1'b0);
    chk("post reset out_pc", s_pc, 32'h3000);
    chk("post reset out_data", s_d, 128'h0);
    chk("post reset occupancy", s_occ, 2'd0);
    chk("post reset in_ready", s_ir, 1'b1);
    chk("post reset stall_cnt", s_sc, 16'd0);

    for (int i = 0; i < 300; i++)
      cycle(0, $urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
            $urandom & 32'hffff_fffc, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(1) == 1, 1, $sformatf("rnd a%0d", i));

    a_rst = 1'b1;
    cycle(1, 1, 0, 0, 32'h0, '0, 1, 0, "b reset");
    cycle(1, 0, 0, 0, 32'h0, '0, 1, 1, "b idle");
    cycle(1, 0, 0, 1, 32'h3100, {4{32'h3100}}, 1, 1, "b push");
    cycle(1, 0, 0, 0, 32'h0, '0, 0, 1, "b stall");
    chk("noskid in_ready low", s_ir, 1'b0);
    chk("noskid occupancy", s_occ, 2'd1);
    cycle(1, 0, 0, 1, 32'h3104, {4{32'h3104}}, 1, 1, "b replace");
    chk("noskid in_ready high", s_ir, 1'b1);
    chk("noskid head pc", s_pc, 32'h3100);
    cycle(1, 0, 0, 0, 32'h0, '0, 1, 1, "b after replace");
    chk("noskid replaced pc", s_pc, 32'h3104);
    chk("noskid occupancy one", s_occ, 2'd1);

    for (int i = 0; i < 300; i++)
      cycle(1, $urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
            $urandom & 32'hffff_fffc, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(1) == 1, 1, $sformatf("rnd b%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
